// File: rtl/rpg_pkg.sv
// Shared types and constants for the rpg_prbs_gen reference pattern generator.
// Holds the FSM encoding, PRBS tap masks and seed sanitising helpers.
package rpg_pkg;

    localparam int LFSR_W = 15;
    localparam int CNT_W  = 32;

    localparam logic [6:0]  TAP7  = 7'h60;
    localparam logic [14:0] TAP15 = 15'h6000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MARK = 3'd2,
        ST_RUN  = 3'd3,
        ST_FIN  = 3'd4
    } rpg_state_e;

    function automatic logic [LFSR_W-1:0] rpg_width_mask(input int poly);
        return (poly == 15) ? 15'h7FFF : 15'h007F;
    endfunction

    function automatic logic [LFSR_W-1:0] rpg_tap_mask(input int poly);
        return (poly == 15) ? TAP15 : {8'h00, TAP7};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is promoted to all-ones.
    function automatic logic [LFSR_W-1:0] rpg_seed_fix(input int poly,
                                                       input logic [LFSR_W-1:0] seed);
        logic [LFSR_W-1:0] s;
        s = seed & rpg_width_mask(poly);
        if (s == '0) begin
            s = rpg_width_mask(poly);
        end
        return s;
    endfunction

endpackage

// File: rtl/rpg_lfsr.sv
// Left-shifting Fibonacci LFSR for PRBS-7 / PRBS-15; serial bit is the MSB.
// load has priority over shift; reset and load both restore the sanitised seed.
module rpg_lfsr
    import rpg_pkg::*;
#(
    parameter int                POLY = 7,
    parameter logic [LFSR_W-1:0] SEED = 15'h7FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    output logic              bit_o,
    output logic [LFSR_W-1:0] state_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = rpg_seed_fix(POLY, SEED);
    localparam logic [LFSR_W-1:0] TAPS     = rpg_tap_mask(POLY);
    localparam logic [LFSR_W-1:0] MASK     = rpg_width_mask(POLY);

    logic [LFSR_W-1:0] s_q, s_d;
    logic              fb;

    always_comb begin
        fb  = ^(s_q & TAPS);
        s_d = s_q;
        if (load) begin
            s_d = SEED_EFF;
        end else if (shift) begin
            s_d = {s_q[LFSR_W-2:0], fb} & MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= SEED_EFF;
        end else begin
            s_q <= s_d;
        end
    end

    assign bit_o   = s_q[POLY-1];
    assign state_o = s_q;

endmodule

// File: rtl/rpg_prbs_gen.sv
// Reference pattern generator: idle-low preamble, single '1' marker, then PRBS.
// Optional error injection is built when RPG_ERR_INJ_EN is defined.
module rpg_prbs_gen
    import rpg_pkg::*;
#(
    parameter int                POLY      = 7,
    parameter logic [LFSR_W-1:0] SEED      = 15'h7FFF,
    parameter int                PRE_ZEROS = 8,
    parameter int                PAT_LEN   = 1024
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BIT_CE,
    input  logic             START,
`ifdef RPG_ERR_INJ_EN
    input  logic             INJ_REQ,
    output logic [15:0]      INJ_CNT,
`endif
    output logic             RPG_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] BIT_CNT
);

    localparam int               PRE_W     = $clog2(PRE_ZEROS);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRE_ZEROS - 1);
    localparam logic [CNT_W-1:0] PAT_LEN_C = CNT_W'(PAT_LEN);
    localparam bit               FREE_RUN  = (PAT_LEN == 0);

    rpg_state_e        state_q, state_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;

    logic              lfsr_load, lfsr_shift, lfsr_bit, lfsr_zero;
    logic [LFSR_W-1:0] lfsr_state;
    logic              prbs_emit;
    logic              inj_flip;

    rpg_lfsr #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (lfsr_load),
        .shift   (lfsr_shift),
        .bit_o   (lfsr_bit),
        .state_o (lfsr_state)
    );

    // A corrupted all-zero state is self-healed by reloading the seed.
    assign lfsr_zero = (lfsr_state == '0);

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        lfsr_load  = lfsr_zero;
        lfsr_shift = 1'b0;
        prbs_emit  = 1'b0;

        if (START && !busy_q) begin
            pend_d = 1'b1;
        end

        if (BIT_CE) begin
            unique case (state_q)
                ST_IDLE: begin
                    out_d = 1'b0;
                    if (pend_q) begin
                        pend_d    = 1'b0;
                        done_d    = 1'b0;
                        cnt_d     = '0;
                        pre_d     = '0;
                        lfsr_load = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = ST_PRE;
                    end
                end
                ST_PRE: begin
                    // The IDLE->PRE edge already drove the first zero.
                    if (pre_q == PRE_LAST) begin
                        out_d   = 1'b1;
                        state_d = ST_MARK;
                    end else begin
                        out_d = 1'b0;
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_MARK: begin
                    prbs_emit = 1'b1;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    if (!FREE_RUN && (cnt_q == PAT_LEN_C)) begin
                        out_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        prbs_emit = 1'b1;
                    end
                end
                ST_FIN: begin
                    out_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (prbs_emit) begin
            out_d      = lfsr_bit ^ inj_flip;
            lfsr_shift = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            pre_q  <= '0;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
        end
    end

`ifdef RPG_ERR_INJ_EN
    logic        inj_pend_q, inj_pend_d;
    logic [15:0] inj_cnt_q, inj_cnt_d;

    // Inversion touches only the driven bit; the LFSR keeps its true sequence.
    always_comb begin
        inj_pend_d = inj_pend_q | INJ_REQ;
        inj_cnt_d  = inj_cnt_q;
        if (prbs_emit && inj_pend_q) begin
            inj_pend_d = INJ_REQ;
            inj_cnt_d  = inj_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            inj_pend_q <= 1'b0;
            inj_cnt_q  <= '0;
        end else begin
            inj_pend_q <= inj_pend_d;
            inj_cnt_q  <= inj_cnt_d;
        end
    end

    assign inj_flip = inj_pend_q;
    assign INJ_CNT  = inj_cnt_q;
`else
    assign inj_flip = 1'b0;
`endif

    assign RPG_OUT = out_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign BIT_CNT = cnt_q;

endmodule

// File: doc/rpg_prbs_gen.md
Name: rpg_prbs_gen

Overview:
- Reference pattern generator, directly upstream of the error-counting comparator.
- Drives the serial test chain into the DUT and supplies the comparator's reference input, so one output is fanned to both.
- Emits, per run: an idle-low preamble, a single '1' sync marker, then a PRBS-7 or PRBS-15 sequence.
- Every bit is held for one bit period set by a clock-enable strobe.

Parameters:
- POLY, default 7. PRBS order; legal values 7 or 15. Taps are x^7+x^6+1 or x^15+x^14+1.
- SEED, default 15'h7FFF. LFSR load value. Truncated to POLY bits. An all-zero result is replaced by all-ones.
- PRE_ZEROS, default 8. Bit periods of '0' before the marker. Minimum 2, so the comparator's edge detector sees a 0->1 transition.
- PAT_LEN, default 1024. PRBS bits per run. 0 means free-run until reset.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  synchronous, active-low reset.
- BIT_CE  in  1  bit-period strobe. State, LFSR and outputs advance only on cycles with BIT_CE=1.
- START  in  1  run request, any cycle. Captured into a pending flag; honoured only in IDLE.
- RPG_OUT  out  1  serial pattern to DUT chain and comparator. Registered.
- BUSY  out  1  high in PRE, MARK, RUN.
- DONE  out  1  sticky run-complete flag. Cleared by next accepted START.
- BIT_CNT  out  32  PRBS bits emitted this run. Saturates at 2^32-1.

Behaviour:
- Reset: checked every CLK edge, independent of BIT_CE, overrides all else.
  - Reset values: RPG_OUT=0, BUSY=0, DONE=0, BIT_CNT=0, state=IDLE, start-pending=0, LFSR=SEED (fixed per above).
- Reset mid-run: aborts immediately; DONE is not set.
- FSM states: IDLE, PRE, MARK, RUN, FIN. Transitions occur only on BIT_CE=1.
- IDLE: RPG_OUT=0.
  - On BIT_CE with pending set: clear pending and DONE, BIT_CNT=0, LFSR=SEED, pre-counter=0, go to PRE.
- PRE: RPG_OUT=0 for PRE_ZEROS bit periods, then go to MARK.
- MARK: RPG_OUT=1 for exactly one bit period, then go to RUN.
- RUN, per BIT_CE:
  - RPG_OUT = s[POLY-1]; fb = s[POLY-1]^s[POLY-2]; s <= {s[POLY-2:0], fb}; BIT_CNT += 1.
  - When BIT_CNT reaches PAT_LEN (PAT_LEN != 0), go to FIN after that bit has been driven for its full period.
- FIN: RPG_OUT=0, BUSY=0, DONE=1 (all registered), then go to IDLE on the same BIT_CE.
- Latency: first PRBS bit appears on RPG_OUT one CLK after the (PRE_ZEROS+2)th accepted BIT_CE following START capture.
- START handling:
  - START while BUSY is ignored and not queued.
  - START coincident with the FIN->IDLE transition is captured and honoured on the next BIT_CE.
- BIT_CE stuck low freezes all outputs; no bits are lost.
- Free-run (PAT_LEN=0): period 2^POLY-1 repeats indefinitely; BIT_CNT saturates; DONE is never set.
- The sync marker is always a single '1' preceded by at least 2 zeros.

Optional Feature:
- Macro RPG_ERR_INJ_EN.
- Defined:
  - Adds input INJ_REQ (1b) and output INJ_CNT (16b, reset 0, wraps).
  - An INJ_REQ pulse sets an inject-pending flag.
  - The next RUN bit is driven inverted; the LFSR state is unaffected, so the sequence realigns on the following bit.
  - INJ_CNT increments and the flag clears.
  - Requests outside RUN remain pending until RUN. Multiple requests before the bit is consumed merge into one.
- Undefined: ports absent, output is always the pure PRBS.

Decomposition:
- Package rpg_pkg:
  - FSM state enum (3b).
  - Tap constants TAP7=7'h60, TAP15=15'h6000.
  - Width constants LFSR_W=15, CNT_W=32.
- One sub-module, rpg_lfsr:
  - Parameterised POLY and SEED.
  - Inputs: load, shift.
  - Output: serial bit and state.
- The top holds the FSM, counters and injection logic.

Test Plan:
- POLY=7, SEED=7'h7F, PRE_ZEROS=8, BIT_CE=1 always, START pulse.
  - Expect RPG_OUT: 8×'0', '1', then 1111111 0 ...
  - Full 127-bit period repeats exactly; BIT_CNT=127 after one period.
- PAT_LEN=16, BIT_CE every 4th CLK.
  - Each bit held 4 CLKs; BUSY falls and DONE rises after the 16th PRBS bit; BIT_CNT=16.
  - Second START clears DONE and replays the identical bit sequence.
- RST_N low for 1 CLK mid-RUN (bit 40).
  - Next cycle: RPG_OUT=0, BUSY=0, DONE=0, BIT_CNT=0.
  - START then restarts from preamble with the SEED sequence.
- START asserted during RUN.
  - Ignored: no restart, DONE timing unchanged.
- SEED=0, POLY=15.
  - LFSR loads all-ones; output is non-stuck with period 32767.
- RPG_ERR_INJ_EN defined; INJ_REQ at RUN bits 10 and 50.
  - Exactly those two bits are inverted vs the golden model; INJ_CNT=2.
  - Downstream comparator error count reads 2.
